// File: rtl/vicuna_cluster_ctrl.sv
// ============================================================================
// Module      : vicuna_cluster_ctrl (+ tlul_pkg)
// Description : Run/reset controller for NumCores Vicuna vector cores.
//               It has a TL-UL register port that holds the boot addresses,
//               the run requests and the completion status. Each core has
//               its own sequencing FSM, which drives that core's reset.
//               Optional macro VICUNA_CLUSTER_CTRL_CYCLE_CNT_EN adds per-core
//               RUN cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module vicuna_cluster_ctrl
  import tlul_pkg::*;
#(
  parameter int unsigned NumCores        = 2,
  parameter int unsigned ResetHoldCycles = 4,
  parameter logic [31:0] BootAddrDefault = 32'h0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  tl_h2d_t                 tl_i,
  output tl_d2h_t                 tl_o,
  input  logic [NumCores-1:0]     core_done_i,
  output logic [NumCores-1:0]     core_rst_no,
  output logic [32*NumCores-1:0]  boot_addr_o,
  output logic                    irq_o
);

  localparam int unsigned HoldW = $clog2(ResetHoldCycles + 1);

  typedef enum logic [1:0] {
    ST_HELD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } core_state_e;

  // Registers
  logic [NumCores-1:0]    run_req;
  logic [NumCores-1:0]    status;
  logic [NumCores-1:0]    irq_en;
  logic [32*NumCores-1:0] boot_addr;
  logic                   irq;

  // Response channel
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic [31:0] d_data;
  logic        d_err;

  // Per-core views gathered from the generate loop
  logic [2*NumCores-1:0]  state_vec;
  logic [32*NumCores-1:0] cycles_vec;
  logic [NumCores-1:0]    status_set;
  logic [NumCores-1:0]    run_next;

  // Request decode
  logic        accept;
  logic        is_get;
  logic        is_put;
  logic [7:0]  offset;
  logic [3:0]  idx;
  logic        idx_ok;
  logic        hit;
  logic        ro;
  logic        sel_run;
  logic        sel_status;
  logic        sel_irqen;
  logic        sel_boot;
  logic [31:0] rdata;
  logic [31:0] state_word;
  logic        err;
  logic        wr;

  assign accept = tl_i.a_valid & ~d_valid;
  assign is_get = (tl_i.a_opcode == Get);
  assign is_put = (tl_i.a_opcode == PutFullData) | (tl_i.a_opcode == PutPartialData);
  assign offset = tl_i.a_address[7:0];
  assign idx    = offset[5:2];
  assign idx_ok = (32'(idx) < NumCores);

  // Address decode and read-data mux
  always_comb begin
    hit        = 1'b0;
    ro         = 1'b0;
    sel_run    = 1'b0;
    sel_status = 1'b0;
    sel_irqen  = 1'b0;
    sel_boot   = 1'b0;
    rdata      = '0;
    state_word = '0;
    state_word[2*NumCores-1:0] = state_vec;
    if (offset[1:0] == 2'b00) begin
      case (offset[7:6])
        2'b00: begin
          case (idx)
            4'h0: begin hit = 1'b1; sel_run    = 1'b1; rdata = 32'(run_req); end
            4'h1: begin hit = 1'b1; sel_status = 1'b1; rdata = 32'(status);  end
            4'h2: begin hit = 1'b1; sel_irqen  = 1'b1; rdata = 32'(irq_en);  end
            4'h3: begin hit = 1'b1; ro         = 1'b1; rdata = state_word;   end
            default: ;
          endcase
        end
        2'b01: begin
          if (idx_ok) begin
            hit      = 1'b1;
            sel_boot = 1'b1;
            for (int c = 0; c < NumCores; c++) begin
              if (idx == 4'(c)) rdata = boot_addr[32*c +: 32];
            end
          end
        end
        2'b10: begin
          if (idx_ok) begin
            hit = 1'b1;
            ro  = 1'b1;
            for (int c = 0; c < NumCores; c++) begin
              if (idx == 4'(c)) rdata = cycles_vec[32*c +: 32];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign err = ~hit | (~is_get & ~is_put) | (is_put & ((tl_i.a_mask != 4'hF) | ro));
  assign wr  = accept & is_put & ~err;

  // The FSMs act on the RUN value being written this cycle, so that a run
  // request reaches RELEASE one cycle after its accept.
  assign run_next = (wr & sel_run) ? tl_i.a_data[NumCores-1:0] : run_req;

  // Single-outstanding TL-UL response register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_valid  <= 1'b0;
      d_opcode <= AccessAck;
      d_size   <= 2'd0;
      d_source <= 8'd0;
      d_data   <= 32'd0;
      d_err    <= 1'b0;
    end else if (accept) begin
      d_valid  <= 1'b1;
      d_opcode <= is_get ? AccessAckData : AccessAck;
      d_size   <= tl_i.a_size;
      d_source <= tl_i.a_source;
      d_data   <= (is_get & ~err) ? rdata : 32'd0;
      d_err    <= err;
    end else if (d_valid & tl_i.d_ready) begin
      d_valid  <= 1'b0;
    end
  end

  // Control registers; a done event beats a same-cycle W1C
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_req <= '0;
      status  <= '0;
      irq_en  <= '0;
      irq     <= 1'b0;
    end else begin
      run_req <= run_next;
      if (wr & sel_irqen) irq_en <= tl_i.a_data[NumCores-1:0];
      status  <= (status & ~((wr & sel_status) ? tl_i.a_data[NumCores-1:0] : '0)) | status_set;
      irq     <= |(status & irq_en);
    end
  end

  // Boot addresses only change while their core is held in reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      boot_addr <= {NumCores{BootAddrDefault}};
    end else begin
      for (int c = 0; c < NumCores; c++) begin
        if (wr && sel_boot && idx == 4'(c) && state_vec[2*c +: 2] == ST_HELD) begin
          boot_addr[32*c +: 32] <= tl_i.a_data;
        end
      end
    end
  end

  for (genvar c = 0; c < NumCores; c++) begin : g_core
    core_state_e      st;
    logic [HoldW-1:0] hold_cnt;
    logic             rst_n;

    assign state_vec[2*c +: 2] = st;
    assign core_rst_no[c]      = rst_n;
    assign status_set[c]       = (st == ST_RUN) & core_done_i[c];

    // Per-core sequencing FSM with registered core reset
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        st       <= ST_HELD;
        hold_cnt <= '0;
        rst_n    <= 1'b0;
      end else begin
        case (st)
          ST_HELD: begin
            if (run_next[c]) begin
              st       <= ST_RELEASE;
              hold_cnt <= '0;
            end
          end
          ST_RELEASE: begin
            if (!run_next[c]) begin
              st <= ST_HELD;
            end else if (hold_cnt == HoldW'(ResetHoldCycles - 1)) begin
              st    <= ST_RUN;
              rst_n <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (!run_next[c]) begin
              st    <= ST_HELD;
              rst_n <= 1'b0;
            end else if (core_done_i[c]) begin
              st    <= ST_DONE;
              rst_n <= 1'b0;
            end
          end
          ST_DONE: begin
            if (!run_next[c]) st <= ST_HELD;
          end
          default: begin
            st    <= ST_HELD;
            rst_n <= 1'b0;
          end
        endcase
      end
    end

`ifdef VICUNA_CLUSTER_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc;

    // Saturating count of cycles spent in RUN, cleared on each new run
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cyc <= 32'd0;
      end else if (st == ST_HELD && run_next[c]) begin
        cyc <= 32'd0;
      end else if (st == ST_RUN && cyc != 32'hFFFF_FFFF) begin
        cyc <= cyc + 32'd1;
      end
    end

    assign cycles_vec[32*c +: 32] = cyc;
`else
    assign cycles_vec[32*c +: 32] = 32'd0;
`endif
  end

  assign boot_addr_o = boot_addr;
  assign irq_o       = irq;

  assign tl_o.d_valid  = d_valid;
  assign tl_o.d_opcode = d_opcode;
  assign tl_o.d_param  = 3'd0;
  assign tl_o.d_size   = d_size;
  assign tl_o.d_source = d_source;
  assign tl_o.d_sink   = 1'b0;
  assign tl_o.d_data   = d_data;
  assign tl_o.d_error  = d_err;
  assign tl_o.a_ready  = ~d_valid;

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:8]};

endmodule

`default_nettype wire
